// File: rtl/uifdma_arb_pkg.sv
// Shared types and constants for the uifdma_arb round-robin FDMA arbiter.
package uifdma_arb_pkg;

  // Upper bound on the number of FDMA clients one arbiter can serve.
  localparam int unsigned MAX_CH = 4;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StBusy,
    StDone
  } arb_state_e;

endpackage

// File: rtl/uifdma_arb_ch.sv
// One arbitration channel: request edge capture, round-robin selection, command
// forwarding and data-handshake routing for a single FDMA direction.
// Optional macro UIFDMA_ARB_TIMEOUT_EN adds a REQ-state timeout and a sticky err flag.
module uifdma_arb_ch
  import uifdma_arb_pkg::*;
#(
  parameter int unsigned NUM_CH     = 2,
  parameter int unsigned ADDR_WIDTH = 32
`ifdef UIFDMA_ARB_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT    = 1024
`endif
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic [NUM_CH*ADDR_WIDTH-1:0] c_addr,
  input  logic [NUM_CH-1:0]            c_areq,
  input  logic [NUM_CH*16-1:0]         c_size,
  output logic [NUM_CH-1:0]            c_busy,
  input  logic [NUM_CH-1:0]            c_ready,
  output logic [NUM_CH-1:0]            c_valid,
  output logic [ADDR_WIDTH-1:0]        m_addr,
  output logic                         m_areq,
  output logic [15:0]                  m_size,
  output logic                         m_ready,
  input  logic                         m_busy,
  input  logic                         m_valid,
  output logic [1:0]                   grant
`ifdef UIFDMA_ARB_TIMEOUT_EN
  ,
  output logic                         err
`endif
);

  localparam int unsigned GrantW = $clog2(MAX_CH);

  arb_state_e              state_q;
  logic [NUM_CH-1:0]       areq_prev_q;
  logic [NUM_CH-1:0]       pend_q, pend_d;
  logic [GrantW-1:0]       ptr_q;
  logic [GrantW-1:0]       grant_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [15:0]             size_q;
  logic                    areq_q;

  logic                    sel_found;
  logic [GrantW-1:0]       sel_idx;
  logic [ADDR_WIDTH-1:0]   sel_addr;
  logic [15:0]             sel_size;
  logic [NUM_CH-1:0]       req_edge;
  logic [NUM_CH-1:0]       pend_clr;
  logic                    active;

`ifdef UIFDMA_ARB_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT + 1);
  logic [CntW-1:0]         cnt_q;
  logic                    err_q;
`endif

  assign req_edge = c_areq & ~areq_prev_q;
  assign active   = (state_q != StIdle);

  // Pick the first pending client at or above ptr, wrapping to the lowest one.
  always_comb begin
    logic              found_hi;
    logic [GrantW-1:0] idx_hi;
    logic [GrantW-1:0] idx_lo;
    found_hi  = 1'b0;
    idx_hi    = '0;
    idx_lo    = '0;
    sel_found = 1'b0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (pend_q[k]) begin
        sel_found = 1'b1;
        idx_lo    = GrantW'(k);
        if (GrantW'(k) >= ptr_q) begin
          found_hi = 1'b1;
          idx_hi   = GrantW'(k);
        end
      end
    end
    sel_idx = found_hi ? idx_hi : idx_lo;
  end

  // Command mux for the candidate and pending-bit update (a fresh edge beats the clear).
  always_comb begin
    sel_addr = '0;
    sel_size = '0;
    pend_clr = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (sel_idx == GrantW'(k)) begin
        sel_addr = c_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
        sel_size = c_size[k*16 +: 16];
        pend_clr[k] = (state_q == StIdle) && sel_found;
      end
    end
    pend_d = (pend_q & ~pend_clr) | req_edge;
  end

  // Arbitration FSM with registered command outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= StIdle;
      areq_prev_q <= '0;
      pend_q      <= '0;
      ptr_q       <= '0;
      grant_q     <= '0;
      addr_q      <= '0;
      size_q      <= '0;
      areq_q      <= 1'b0;
`ifdef UIFDMA_ARB_TIMEOUT_EN
      cnt_q       <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      areq_prev_q <= c_areq;
      pend_q      <= pend_d;
      unique case (state_q)
        StIdle: begin
          if (sel_found) begin
            grant_q <= sel_idx;
            addr_q  <= sel_addr;
            size_q  <= sel_size;
            areq_q  <= 1'b1;
            state_q <= StReq;
`ifdef UIFDMA_ARB_TIMEOUT_EN
            cnt_q   <= '0;
`endif
          end
        end
        StReq: begin
          if (m_busy) begin
            areq_q  <= 1'b0;
            state_q <= StBusy;
`ifdef UIFDMA_ARB_TIMEOUT_EN
          end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
            // Engine never answered: abandon this grant, the client must re-request.
            areq_q  <= 1'b0;
            err_q   <= 1'b1;
            state_q <= StDone;
          end else begin
            cnt_q   <= cnt_q + 1'b1;
`endif
          end
        end
        StBusy: begin
          if (!m_busy) begin
            state_q <= StDone;
          end
        end
        StDone: begin
          ptr_q   <= (grant_q == GrantW'(NUM_CH - 1)) ? '0 : grant_q + 1'b1;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Per-client busy/valid decode and ready mux for the granted client.
  always_comb begin
    c_busy  = '0;
    c_valid = '0;
    m_ready = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (grant_q == GrantW'(k)) begin
        c_busy[k]  = active;
        c_valid[k] = m_valid && (state_q == StBusy);
        m_ready    = c_ready[k];
      end
    end
  end

  assign m_addr = addr_q;
  assign m_size = size_q;
  assign m_areq = areq_q;
  assign grant  = 2'(grant_q);
`ifdef UIFDMA_ARB_TIMEOUT_EN
  assign err    = err_q;
`endif

endmodule

// File: rtl/uifdma_arb.sv
// Round-robin arbiter sharing one FDMA engine (independent write and read channels)
// between up to four clients. Optional macro UIFDMA_ARB_TIMEOUT_EN enables the REQ
// timeout and the arb_err status port.
module uifdma_arb
  import uifdma_arb_pkg::*;
#(
  parameter int unsigned NUM_CH         = 2,
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned AXI_DATA_WIDTH = 128,
  parameter int unsigned TIMEOUT        = 1024
) (
  input  logic                             ui_clk,
  input  logic                             ui_rstn,
  // Client write side
  input  logic [NUM_CH*AXI_ADDR_WIDTH-1:0] cw_waddr,
  input  logic [NUM_CH-1:0]                cw_wareq,
  input  logic [NUM_CH*16-1:0]             cw_wsize,
  output logic [NUM_CH-1:0]                cw_wbusy,
  input  logic [NUM_CH*AXI_DATA_WIDTH-1:0] cw_wdata,
  output logic [NUM_CH-1:0]                cw_wvalid,
  input  logic [NUM_CH-1:0]                cw_wready,
  // Client read side
  input  logic [NUM_CH*AXI_ADDR_WIDTH-1:0] cr_raddr,
  input  logic [NUM_CH-1:0]                cr_rareq,
  input  logic [NUM_CH*16-1:0]             cr_rsize,
  output logic [NUM_CH-1:0]                cr_rbusy,
  output logic [AXI_DATA_WIDTH-1:0]        cr_rdata,
  output logic [NUM_CH-1:0]                cr_rvalid,
  input  logic [NUM_CH-1:0]                cr_rready,
  // FDMA engine write side
  output logic [AXI_ADDR_WIDTH-1:0]        fdma_waddr,
  output logic                             fdma_wareq,
  output logic [15:0]                      fdma_wsize,
  input  logic                             fdma_wbusy,
  output logic [AXI_DATA_WIDTH-1:0]        fdma_wdata,
  input  logic                             fdma_wvalid,
  output logic                             fdma_wready,
  // FDMA engine read side
  output logic [AXI_ADDR_WIDTH-1:0]        fdma_raddr,
  output logic                             fdma_rareq,
  output logic [15:0]                      fdma_rsize,
  input  logic                             fdma_rbusy,
  input  logic [AXI_DATA_WIDTH-1:0]        fdma_rdata,
  input  logic                             fdma_rvalid,
  output logic                             fdma_rready,
  // Status
  output logic [1:0]                       wgrant,
  output logic [1:0]                       rgrant
`ifdef UIFDMA_ARB_TIMEOUT_EN
  ,
  output logic [1:0]                       arb_err
`endif
);

`ifdef UIFDMA_ARB_TIMEOUT_EN
  logic wr_err;
  logic rd_err;
  assign arb_err = {rd_err, wr_err};
`endif

  uifdma_arb_ch #(
    .NUM_CH     (NUM_CH),
    .ADDR_WIDTH (AXI_ADDR_WIDTH)
`ifdef UIFDMA_ARB_TIMEOUT_EN
    ,
    .TIMEOUT    (TIMEOUT)
`endif
  ) u_wr_ch (
    .clk     (ui_clk),
    .rstn    (ui_rstn),
    .c_addr  (cw_waddr),
    .c_areq  (cw_wareq),
    .c_size  (cw_wsize),
    .c_busy  (cw_wbusy),
    .c_ready (cw_wready),
    .c_valid (cw_wvalid),
    .m_addr  (fdma_waddr),
    .m_areq  (fdma_wareq),
    .m_size  (fdma_wsize),
    .m_ready (fdma_wready),
    .m_busy  (fdma_wbusy),
    .m_valid (fdma_wvalid),
    .grant   (wgrant)
`ifdef UIFDMA_ARB_TIMEOUT_EN
    ,
    .err     (wr_err)
`endif
  );

  uifdma_arb_ch #(
    .NUM_CH     (NUM_CH),
    .ADDR_WIDTH (AXI_ADDR_WIDTH)
`ifdef UIFDMA_ARB_TIMEOUT_EN
    ,
    .TIMEOUT    (TIMEOUT)
`endif
  ) u_rd_ch (
    .clk     (ui_clk),
    .rstn    (ui_rstn),
    .c_addr  (cr_raddr),
    .c_areq  (cr_rareq),
    .c_size  (cr_rsize),
    .c_busy  (cr_rbusy),
    .c_ready (cr_rready),
    .c_valid (cr_rvalid),
    .m_addr  (fdma_raddr),
    .m_areq  (fdma_rareq),
    .m_size  (fdma_rsize),
    .m_ready (fdma_rready),
    .m_busy  (fdma_rbusy),
    .m_valid (fdma_rvalid),
    .grant   (rgrant)
`ifdef UIFDMA_ARB_TIMEOUT_EN
    ,
    .err     (rd_err)
`endif
  );

  // Write data comes from the currently granted client.
  always_comb begin
    fdma_wdata = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (wgrant == 2'(k)) begin
        fdma_wdata = cw_wdata[k*AXI_DATA_WIDTH +: AXI_DATA_WIDTH];
      end
    end
  end

  // Read data is broadcast; only rvalid is steered.
  assign cr_rdata = fdma_rdata;

endmodule
